// File: rtl/drp_responder_if.sv
// DRP bus between the SysMon reader logic (master) and the emulated register
// file (slave).
interface drp_responder_if;
  logic [6:0]  DADDR_IN;
  logic        DEN_IN;
  logic        DWE_IN;
  logic [15:0] DI_IN;
  logic [15:0] DO_OUT;
  logic        DRDY_OUT;

  modport master (
    output DADDR_IN, DEN_IN, DWE_IN, DI_IN,
    input  DO_OUT, DRDY_OUT
  );

  modport slave (
    input  DADDR_IN, DEN_IN, DWE_IN, DI_IN,
    output DO_OUT, DRDY_OUT
  );
endinterface

// File: rtl/drp_responder.sv
// DRP slave emulating the SysMon temperature/voltage register file; answers
// each accepted request with a DRDY strobe a fixed LATENCY after acceptance.
//
// state  | meaning
// IDLE   | waiting for DEN_IN; request accepted on the edge it is seen
// WAIT   | read data already snapshotted, timer counting down to zero
// RESP   | DRDY_OUT high for this single cycle, DO_OUT carries the snapshot
module drp_responder #(
  parameter int LATENCY = 4,
  parameter int CNT_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  drp_responder_if.slave      drp,
  input  logic [9:0]          i_temp_sample,
  input  logic [9:0]          i_vccint_sample,
  input  logic [9:0]          i_vccaux_sample,
  input  logic                i_sample_valid,
  output logic                o_busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  logic [1:0]       r_state;
  logic [3:0]       r_timer;
  logic [15:0]      r_snap;
  logic [15:0]      r_do;
  logic             r_drdy;
  logic [CNT_W-1:0] r_cnt;
  logic [9:0]       r_temp;
  logic [9:0]       r_vccint;
  logic [9:0]       r_vccaux;
  logic [9:0]       r_max;
  logic [9:0]       r_min;
  logic [15:0]      r_cfg0;
  logic [15:0]      r_cfg1;
  logic [15:0]      r_cfg2;

  logic             w_accept;
  logic [15:0]      w_rd_data;

  assign w_accept     = (r_state == S_IDLE) && drp.DEN_IN;
  assign o_busy       = (r_state != S_IDLE);
  assign drp.DO_OUT   = r_do;
  assign drp.DRDY_OUT = r_drdy;

  // Codes are stored 10 bits wide and left-justified only on the way out.
  always_comb begin
    w_rd_data = 16'h0000;
    case (drp.DADDR_IN)
      7'h00:   w_rd_data = {r_temp, 6'b0};
      7'h01:   w_rd_data = {r_vccint, 6'b0};
      7'h02:   w_rd_data = {r_vccaux, 6'b0};
      7'h20:   w_rd_data = {r_max, 6'b0};
      7'h24:   w_rd_data = {r_min, 6'b0};
      7'h3F:   w_rd_data = 16'(r_cnt);
      7'h40:   w_rd_data = r_cfg0;
      7'h41:   w_rd_data = r_cfg1;
      7'h42:   w_rd_data = r_cfg2;
      default: w_rd_data = 16'h0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_timer <= 4'd0;
      r_snap  <= 16'h0000;
      r_do    <= 16'h0000;
      r_drdy  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_drdy <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (drp.DEN_IN) begin
            r_state <= S_WAIT;
            r_timer <= LAT_M1;
            r_snap  <= drp.DWE_IN ? 16'h0000 : w_rd_data;
          end
        end
        S_WAIT: begin
          if (r_timer == 4'd0) begin
            r_state <= S_RESP;
            r_do    <= r_snap;
            r_drdy  <= 1'b1;
            r_cnt   <= r_cnt + CNT_W'(1);
          end else begin
            r_timer <= r_timer - 4'd1;
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Register file: the read snapshot above sees these values before this edge's update.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_temp   <= 10'h000;
      r_vccint <= 10'h000;
      r_vccaux <= 10'h000;
      r_max    <= 10'h000;
      r_min    <= 10'h3FF;
      r_cfg0   <= 16'h0000;
      r_cfg1   <= 16'h0000;
      r_cfg2   <= 16'h0000;
    end else begin
      if (w_accept && drp.DWE_IN) begin
        case (drp.DADDR_IN)
          7'h40:   r_cfg0 <= drp.DI_IN;
          7'h41:   r_cfg1 <= drp.DI_IN;
          7'h42:   r_cfg2 <= drp.DI_IN;
          default: ;
        endcase
      end
      if (i_sample_valid) begin
        r_temp   <= i_temp_sample;
        r_vccint <= i_vccint_sample;
        r_vccaux <= i_vccaux_sample;
        if (i_temp_sample > r_max) r_max <= i_temp_sample;
        if (i_temp_sample < r_min) r_min <= i_temp_sample;
      end
    end
  end

endmodule

// File: tb/tb_drp_responder.sv
// Bench for drp_responder: two instances (16-bit and 4-bit transaction counter)
// share one stimulus and are compared every cycle against a cycle-number model.
module tb_drp_responder;
  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  addr = 7'h00;
  logic        den = 1'b0;
  logic        dwe = 1'b0;
  logic [15:0] di = 16'h0000;
  logic [9:0]  temp_s = 10'h000;
  logic [9:0]  vint_s = 10'h000;
  logic [9:0]  vaux_s = 10'h000;
  logic        sv = 1'b0;
  logic        busy1, busy2;

  int n_checks = 0;
  int n_fail   = 0;

  drp_responder_if u_if1 ();
  drp_responder_if u_if2 ();

  assign u_if1.DADDR_IN = addr;
  assign u_if1.DEN_IN   = den;
  assign u_if1.DWE_IN   = dwe;
  assign u_if1.DI_IN    = di;
  assign u_if2.DADDR_IN = addr;
  assign u_if2.DEN_IN   = den;
  assign u_if2.DWE_IN   = dwe;
  assign u_if2.DI_IN    = di;

  drp_responder #(.LATENCY(LAT), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst(rst), .drp(u_if1.slave),
    .i_temp_sample(temp_s), .i_vccint_sample(vint_s), .i_vccaux_sample(vaux_s),
    .i_sample_valid(sv), .o_busy(busy1)
  );

  drp_responder #(.LATENCY(LAT), .CNT_W(4)) u_dut2 (
    .clk(clk), .rst(rst), .drp(u_if2.slave),
    .i_temp_sample(temp_s), .i_vccint_sample(vint_s), .i_vccaux_sample(vaux_s),
    .i_sample_valid(sv), .o_busy(busy2)
  );

  always #5 clk = ~clk;

  // reference model: register contents plus transaction timing as edge numbers
  logic [9:0]  m_temp, m_vint, m_vaux, m_max, m_min;
  logic [15:0] m_cfg [3];
  int          m_cnt;
  int          e_num     = 0;
  int          next_free = 0;
  int          pend_edge = -1;
  bit          pend_act  = 1'b0;
  int          drdy_at   = -1;
  logic [15:0] pd1, pd2, do1, do2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h (edge %0d)", tag, got, exp, e_num);
    end
  endtask

  function automatic logic [15:0] mread(input logic [6:0] a, input int cw);
    case (a)
      7'h00:   return {m_temp, 6'b0};
      7'h01:   return {m_vint, 6'b0};
      7'h02:   return {m_vaux, 6'b0};
      7'h20:   return {m_max, 6'b0};
      7'h24:   return {m_min, 6'b0};
      7'h3F:   return 16'(m_cnt % (1 << cw));
      7'h40:   return m_cfg[0];
      7'h41:   return m_cfg[1];
      7'h42:   return m_cfg[2];
      default: return 16'h0000;
    endcase
  endfunction

  task automatic model_edge();
    if (rst) begin
      pend_act = 1'b0; drdy_at = -1; do1 = '0; do2 = '0; m_cnt = 0;
      m_temp = '0; m_vint = '0; m_vaux = '0; m_max = 10'h000; m_min = 10'h3FF;
      for (int i = 0; i < 3; i++) m_cfg[i] = '0;
      next_free = e_num + 1;
    end else begin
      if (pend_act && e_num == pend_edge) begin
        do1 = pd1; do2 = pd2; m_cnt++; drdy_at = e_num; pend_act = 1'b0;
      end
      if (!pend_act && e_num >= next_free && den) begin
        pend_act  = 1'b1;
        pend_edge = e_num + LAT;
        next_free = e_num + LAT + 2;
        pd1 = dwe ? 16'h0000 : mread(addr, 16);
        pd2 = dwe ? 16'h0000 : mread(addr, 4);
        if (dwe && addr >= 7'h40 && addr <= 7'h42) m_cfg[int'(addr) - 64] = di;
      end
      if (sv) begin
        m_temp = temp_s; m_vint = vint_s; m_vaux = vaux_s;
        if (temp_s > m_max) m_max = temp_s;
        if (temp_s < m_min) m_min = temp_s;
      end
    end
  endtask

  task automatic tick();
    bit drdy_exp, busy_exp;
    @(posedge clk);
    e_num++;
    model_edge();
    #1;
    drdy_exp = (drdy_at == e_num);
    busy_exp = pend_act || drdy_exp;
    check("cyc_drdy1", u_if1.DRDY_OUT, drdy_exp);
    check("cyc_drdy2", u_if2.DRDY_OUT, drdy_exp);
    check("cyc_busy1", busy1, busy_exp);
    check("cyc_busy2", busy2, busy_exp);
    check("cyc_do1", u_if1.DO_OUT, do1);
    check("cyc_do2", u_if2.DO_OUT, do2);
  endtask

  // one request, wait (bounded) for DRDY, compare DO of both instances, then settle to IDLE
  task automatic xfer(input logic [6:0] a, input logic w, input logic [15:0] d,
                      input string tag, input logic [15:0] exp1, input logic [15:0] exp2);
    int n = 0;
    addr = a; dwe = w; di = d; den = 1'b1;
    tick();
    den = 1'b0; sv = 1'b0;
    while (!u_if1.DRDY_OUT && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_drdy_seen"}, u_if1.DRDY_OUT, 1'b1);
    check({tag, "_do1"}, u_if1.DO_OUT, exp1);
    check({tag, "_do2"}, u_if2.DO_OUT, exp2);
    tick();
  endtask

  initial begin
    logic [6:0] addr_set [9];
    int pulses, first_p, last_p;
    addr_set = '{7'h00, 7'h01, 7'h02, 7'h20, 7'h24, 7'h3F, 7'h40, 7'h41, 7'h42};

    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_busy", busy1, 1'b0);
    check("rst_drdy", u_if1.DRDY_OUT, 1'b0);
    check("rst_do", u_if1.DO_OUT, 16'h0000);
    xfer(7'h20, 1'b0, 16'h0, "rst_max", 16'h0000, 16'h0000);
    xfer(7'h24, 1'b0, 16'h0, "rst_min", 16'hFFC0, 16'hFFC0);

    // sample then read temperature; DO must hold after DRDY
    temp_s = 10'h155; vint_s = 10'h2AA; vaux_s = 10'h0F0; sv = 1'b1;
    tick();
    sv = 1'b0;
    xfer(7'h00, 1'b0, 16'h0, "temp", 16'h5540, 16'h5540);
    xfer(7'h01, 1'b0, 16'h0, "vccint", 16'hAA80, 16'hAA80);
    repeat (5) tick();
    check("do_held", u_if1.DO_OUT, 16'hAA80);

    // DEN/DWE held high on a config register: one transaction every LAT+2 cycles
    addr = 7'h41; dwe = 1'b1; di = 16'hA5A5; den = 1'b1;
    pulses = 0; first_p = 0; last_p = 0;
    for (int i = 1; i <= 24; i++) begin
      tick();
      if (u_if1.DRDY_OUT) begin
        if (pulses == 0) first_p = i;
        last_p = i;
        pulses++;
      end
    end
    den = 1'b0; dwe = 1'b0;
    check("held_pulses", pulses, 4);
    check("held_spacing", last_p - first_p, 3 * (LAT + 2));
    repeat (LAT + 2) tick();
    xfer(7'h41, 1'b0, 16'h0, "cfg_rd", 16'hA5A5, 16'hA5A5);
    xfer(7'h00, 1'b1, 16'h1234, "ro_wr", 16'h0000, 16'h0000);
    xfer(7'h00, 1'b0, 16'h0, "ro_kept", 16'h5540, 16'h5540);

    // min/max tracking and unmapped read
    foreach (addr_set[i]) if (i < 3) begin
      temp_s = (i == 0) ? 10'h200 : (i == 1) ? 10'h100 : 10'h300;
      sv = 1'b1;
      tick();
    end
    sv = 1'b0;
    xfer(7'h20, 1'b0, 16'h0, "max", 16'hC000, 16'hC000);
    xfer(7'h24, 1'b0, 16'h0, "min", 16'h4000, 16'h4000);
    xfer(7'h30, 1'b0, 16'h0, "unmapped", 16'h0000, 16'h0000);

    // sample on the accept edge: read sees the old code
    temp_s = 10'h001; sv = 1'b1;
    tick();
    temp_s = 10'h3FF; sv = 1'b1;
    xfer(7'h00, 1'b0, 16'h0, "same_edge", 16'h0040, 16'h0040);
    xfer(7'h00, 1'b0, 16'h0, "after_same", 16'hFFC0, 16'hFFC0);

    // reset while waiting, then counter wrap on the 4-bit instance
    addr = 7'h00; dwe = 1'b0; den = 1'b1;
    tick();
    den = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_do", u_if1.DO_OUT, 16'h0000);
    check("abort_busy", busy1, 1'b0);
    repeat (LAT + 3) tick();
    xfer(7'h3F, 1'b0, 16'h0, "cnt_zero", 16'h0000, 16'h0000);
    for (int i = 0; i < 15; i++) xfer(7'h00, 1'b0, 16'h0, "cnt_fill", 16'h0000, 16'h0000);
    xfer(7'h3F, 1'b0, 16'h0, "cnt_wrap", 16'h0010, 16'h0000);

    // randomized traffic, checked every cycle by the model
    for (int i = 0; i < 600; i++) begin
      den    = ($urandom_range(0, 2) != 0);
      dwe    = ($urandom_range(0, 3) == 0);
      addr   = ($urandom_range(0, 9) == 9) ? 7'($urandom) : addr_set[$urandom_range(0, 8)];
      di     = 16'($urandom);
      sv     = ($urandom_range(0, 4) == 0);
      temp_s = 10'($urandom);
      vint_s = 10'($urandom);
      vaux_s = 10'($urandom);
      rst    = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0; den = 1'b0; sv = 1'b0;
    repeat (LAT + 3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
